// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one byte-addressed data memory between the pipeline MEM stage (port 0) and the debug loader (port 1).
module data_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0Req,
  input  logic              p0We,
  input  logic [1:0]        p0Size,
  input  logic [ADDR_W-1:0] p0Addr,
  input  logic [DATA_W-1:0] p0WData,
  output logic              p0Gnt,
  output logic              p0RValid,
  input  logic              p1Req,
  input  logic              p1We,
  input  logic [1:0]        p1Size,
  input  logic [ADDR_W-1:0] p1Addr,
  input  logic [DATA_W-1:0] p1WData,
  output logic              p1Gnt,
  output logic              p1RValid,
  output logic [DATA_W-1:0] rData,
  output logic              memWrEnable,
  output logic              memRdEnable,
  output logic [1:0]        memNumberOfByte,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memIn,
  input  logic [DATA_W-1:0] memOut,
  output logic              busy
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] starve_cnt;
  logic owner, is_rd, illegal, take, pick1, sel_we;
  logic [1:0] sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  always_comb begin
    take      = p0Req | p1Req;
    pick1     = p1Req & (~p0Req | starve_cnt == LIMIT);
    sel_we    = pick1 ? p1We : p0We;
    sel_size  = pick1 ? p1Size : p0Size;
    sel_addr  = pick1 ? p1Addr : p0Addr;
    sel_wdata = pick1 ? p1WData : p0WData;
    state_n   = state == IDLE ? (take ? CMD : IDLE) :
                state == CMD  ? (is_rd ? RESP : IDLE) : IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      {p0Gnt, p1Gnt, p0RValid, p1RValid, memWrEnable, memRdEnable} <= '0;
      {owner, is_rd, illegal} <= '0;
      memNumberOfByte <= '0;
      memAddress      <= '0;
      memIn           <= '0;
      rData           <= '0;
      starve_cnt      <= '0;
    end else begin
      {p0Gnt, p1Gnt, p0RValid, p1RValid, memWrEnable, memRdEnable} <= '0;
      if (state == IDLE) begin
        starve_cnt <= (~p1Req | pick1) ? '0 : (starve_cnt == LIMIT ? LIMIT : starve_cnt + 1'b1);
        if (take) begin
          owner           <= pick1;
          is_rd           <= ~sel_we;
          illegal         <= sel_size == 2'b11;
          memWrEnable     <= sel_we;
          // an illegal-size read runs the normal timing but never strobes the memory
          memRdEnable     <= ~sel_we & (sel_size != 2'b11);
          memNumberOfByte <= sel_size;
          memAddress      <= sel_addr;
          memIn           <= sel_wdata;
          p0Gnt           <= ~pick1;
          p1Gnt           <= pick1;
        end
      end
      if (state == RESP) begin
        rData    <= illegal ? '0 : memOut;
        p0RValid <= ~owner;
        p1RValid <= owner;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed vector table plus hand sequences for starvation, reset-in-RESP and late requests.
module tb_data_mem_arbiter;
  logic clk = 0, reset = 0;
  logic p0Req = 0, p0We = 0, p1Req = 0, p1We = 0;
  logic [1:0] p0Size = 0, p1Size = 0;
  logic [15:0] p0Addr = 0, p1Addr = 0, p0WData = 0, p1WData = 0;
  logic p0Gnt, p0RValid, p1Gnt, p1RValid, memWrEnable, memRdEnable, busy;
  logic [15:0] rData, memAddress, memIn;
  logic [15:0] memOut = 16'hA5A5;
  logic [1:0] memNumberOfByte;
  logic [7:0] mem [0:255];
  int checks = 0, errors = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0Req(p0Req), .p0We(p0We), .p0Size(p0Size), .p0Addr(p0Addr), .p0WData(p0WData),
    .p0Gnt(p0Gnt), .p0RValid(p0RValid),
    .p1Req(p1Req), .p1We(p1We), .p1Size(p1Size), .p1Addr(p1Addr), .p1WData(p1WData),
    .p1Gnt(p1Gnt), .p1RValid(p1RValid),
    .rData(rData), .memWrEnable(memWrEnable), .memRdEnable(memRdEnable),
    .memNumberOfByte(memNumberOfByte), .memAddress(memAddress), .memIn(memIn),
    .memOut(memOut), .busy(busy)
  );

  always #5 clk = ~clk;

  // little-endian memory; read sizes: 00 halfword, 01 zero-extended byte, 10 sign-extended byte
  always @(posedge clk) begin
    if (memWrEnable) begin
      mem[memAddress[7:0]] <= memIn[7:0];
      if (memNumberOfByte == 2'b10) mem[memAddress[7:0] + 8'd1] <= memIn[15:8];
    end
    if (memRdEnable)
      memOut <= memNumberOfByte == 2'b00 ? {mem[memAddress[7:0] + 8'd1], mem[memAddress[7:0]]} :
                memNumberOfByte == 2'b01 ? {8'h00, mem[memAddress[7:0]]} :
                memNumberOfByte == 2'b10 ? {{8{mem[memAddress[7:0]][7]}}, mem[memAddress[7:0]]} : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    chk("enables_exclusive", {31'd0, memWrEnable & memRdEnable}, 0);
    chk("gnt_exclusive", {31'd0, p0Gnt & p1Gnt}, 0);
  end

  typedef struct {
    logic port, we;
    logic [1:0] size;
    logic [15:0] addr, wdata, exp;
  } vec_t;

  task automatic xfer(input vec_t v);
    if (v.port) begin p1Req = 1; p1We = v.we; p1Size = v.size; p1Addr = v.addr; p1WData = v.wdata; end
    else begin p0Req = 1; p0We = v.we; p0Size = v.size; p0Addr = v.addr; p0WData = v.wdata; end
    @(posedge clk); #1;
    chk("gnt", {30'd0, p1Gnt, p0Gnt}, v.port ? 2 : 1);
    chk("cmd_enables", {30'd0, memWrEnable, memRdEnable}, {30'd0, v.we, ~v.we & (v.size != 2'b11)});
    chk("cmd_addr", memAddress, v.addr);
    chk("cmd_size", memNumberOfByte, v.size);
    if (v.we) chk("cmd_wdata", memIn, v.wdata);
    p0Req = 0; p1Req = 0;
    @(posedge clk); #1;
    chk("post_cmd", {busy, p0Gnt, p1Gnt, memWrEnable, memRdEnable}, v.we ? 0 : 5'b10000);
    if (!v.we) begin
      @(posedge clk); #1;
      chk("rvalid", {29'd0, busy, p1RValid, p0RValid}, v.port ? 2 : 1);
      chk("rdata", rData, v.exp);
      @(posedge clk); #1;
      chk("rvalid_drop", {30'd0, p1RValid, p0RValid}, 0);
    end
  endtask

  initial begin
    vec_t tbl [10];
    logic [9:0] seq;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[4] = 8'h83;
    tbl[0] = '{0, 1, 2'b10, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1] = '{0, 0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1, 0, 2'b10, 16'h0004, 16'h0000, 16'hFF83};
    tbl[3] = '{1, 0, 2'b01, 16'h0004, 16'h0000, 16'h0083};
    tbl[4] = '{0, 0, 2'b11, 16'h0010, 16'h0000, 16'h0000};
    tbl[5] = '{1, 1, 2'b00, 16'h0020, 16'h1234, 16'h0000};
    tbl[6] = '{0, 0, 2'b00, 16'h0020, 16'h0000, 16'h0034};
    tbl[7] = '{1, 1, 2'b10, 16'h0030, 16'hA55A, 16'h0000};
    tbl[8] = '{1, 0, 2'b00, 16'h0030, 16'h0000, 16'hA55A};
    tbl[9] = '{0, 0, 2'b10, 16'h0031, 16'h0000, 16'hFFA5};
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {p0Gnt, p1Gnt, p0RValid, p1RValid, memWrEnable, memRdEnable, busy, memNumberOfByte}, 0);
    chk("reset_buses", {memAddress, memIn}, 0);
    chk("reset_rdata", rData, 0);
    reset = 1;
    for (int i = 0; i < 10; i++) xfer(tbl[i]);

    p0Req = 1; p0We = 1; p0Size = 0; p0Addr = 16'h0040; p0WData = 16'h1111;
    p1Req = 1; p1We = 1; p1Size = 0; p1Addr = 16'h0050; p1WData = 16'h2222;
    seq = 0; n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(posedge clk); #1;
      if (p0Gnt | p1Gnt) begin seq[9 - n] = p1Gnt; n++; end
    end
    p0Req = 0; p1Req = 0;
    chk("starve_grants", n, 10);
    chk("starve_seq", {22'd0, seq}, 10'b0000100001);
    repeat (2) @(posedge clk); #1;
    chk("starve_idle", {31'd0, busy}, 0);

    p1Req = 1; p1We = 0; p1Size = 2'b01; p1Addr = 16'h0004;
    @(posedge clk); #1;
    chk("rst_gnt", {31'd0, p1Gnt}, 1);
    p1Req = 0;
    @(posedge clk); #1;
    chk("rst_in_resp", {31'd0, busy}, 1);
    reset = 0;
    @(posedge clk); #1;
    chk("rst_outputs", {p0Gnt, p1Gnt, p0RValid, p1RValid, memWrEnable, memRdEnable, busy, memNumberOfByte}, 0);
    chk("rst_buses", {memAddress, memIn}, 0);
    chk("rst_rdata", rData, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("rst_no_rvalid", {30'd0, p1RValid, p0RValid}, 0);
    xfer('{1, 0, 2'b01, 16'h0004, 16'h0000, 16'h0083});

    p1Req = 1; p1We = 1; p1Size = 2'b10; p1Addr = 16'h0060; p1WData = 16'h7777;
    @(posedge clk); #1;
    chk("late_p1_gnt", {30'd0, p1Gnt, p0Gnt}, 2);
    p1Req = 0;
    p0Req = 1; p0We = 0; p0Size = 2'b00; p0Addr = 16'h0060;
    @(posedge clk); #1;
    chk("late_ignored", {29'd0, busy, p0Gnt, memWrEnable}, 0);
    @(posedge clk); #1;
    chk("late_p0_gnt", {30'd0, p0Gnt, memRdEnable}, 3);
    p0Req = 0;
    repeat (2) @(posedge clk); #1;
    chk("late_rvalid", {31'd0, p0RValid}, 1);
    chk("late_rdata", rData, 16'h7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters.
- Port 0 is the pipeline MEM stage. Port 1 is the debug/program loader.
- Registers the winning request, drives the memory command pins (wrEnable, rdEnable, numberOfByte, address, in) for exactly one cycle, and captures read data one cycle later.
- Fixed priority to port 0, with a starvation guard for port 1.

Parameters:
- ADDR_W, 16, address width passed to memory.
- DATA_W, 16, data width.
- STARVE_LIMIT, 4, max consecutive port-0 grants while port 1 is pending before port 1 is forced to win.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- p0Req  in  1  port-0 request. Held until p0Gnt is seen.
- p0We  in  1  port-0 write (1) / read (0).
- p0Size  in  2  numberOfByte code for port 0.
- p0Addr  in  ADDR_W  port-0 byte address.
- p0WData  in  DATA_W  port-0 write data.
- p0Gnt  out  1  one-cycle grant pulse to port 0.
- p0RValid  out  1  one-cycle read-data-valid to port 0.
- p1Req, p1We, p1Size, p1Addr, p1WData, p1Gnt, p1RValid: same as port 0, for port 1.
- rData  out  DATA_W  read data. Valid only while p0RValid or p1RValid is high.
- memWrEnable  out  1  to memory wrEnable.
- memRdEnable  out  1  to memory rdEnable.
- memNumberOfByte  out  2  to memory numberOfByte.
- memAddress  out  ADDR_W  to memory address.
- memIn  out  DATA_W  to memory in.
- memOut  in  DATA_W  from memory out. Valid in the cycle after a read command edge.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE. All outputs 0: gnts, rValids, mem enables, memNumberOfByte, memAddress, memIn, rData, busy. starveCnt=0.
- Reset mid-operation cancels the transaction: no rValid is produced. A write whose command edge coincides with the reset edge is not guaranteed.
- States: IDLE, CMD, RESP.
- IDLE, with at least one req high at an edge:
  - Pick the winner.
  - Register its We/Size/Addr/WData onto the mem* pins.
  - Set memWrEnable=We or memRdEnable=~We.
  - Pulse the winner's gnt. Record owner. Go to CMD.
- CMD, one cycle:
  - mem* pins are stable and gnt is high. Memory acts at the closing edge.
  - At that edge: clear both enables and gnt.
  - Write: go to IDLE.
  - Read: go to RESP.
- RESP, one cycle:
  - At the closing edge, capture memOut into rData.
  - Pulse the owner's RValid for the following cycle. Go to IDLE.
  - rData holds its value until the next read capture.
- Latency, measured from the edge that samples req:
  - Write: gnt in the next cycle; memory committed 2 edges later.
  - Read: rValid in the cycle after the 3rd edge.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Requests are sampled only in IDLE. Req is ignored in CMD and RESP.
- A requester must drop req, or present a new request, after the edge at which it sees gnt.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: port 0 wins unless starveCnt==STARVE_LIMIT, in which case port 1 wins.
- starveCnt:
  - +1 (saturating at STARVE_LIMIT) on each port-0 grant while p1Req==1.
  - Cleared on a port-1 grant, or at any IDLE edge with p1Req==0.
- Size handling: Size is passed unmodified to the memory. Write encoding: 10 = two bytes, anything else = low byte only.
- Read with Size==11 (illegal):
  - Goes through the same CMD/RESP timing, but memRdEnable stays 0.
  - rData=0 with RValid asserted.
- Addresses pass through unmodified. Wrap at 16'hFFFF is the memory's concern.
- memWrEnable and memRdEnable are never high simultaneously. Neither is ever high outside CMD.

Test Plan:
- Reset, then port-0 write of Addr=0x0010, WData=0xBEEF, Size=10 (req at edge 0).
  -> p0Gnt high in cycle 1. memWrEnable high for exactly 1 cycle.
  -> A later port-0 read of 0x0010 with Size=00 returns rData=0xBEEF with p0RValid 3 cycles after its req edge.
- Port-1 read of Addr=0x0004, Size=10, where memory byte is 0x83.
  -> p1RValid pulse and rData=0xFF83.
  -> Same access with Size=01 -> rData=0x0083.
- p0Req and p1Req held high continuously, STARVE_LIMIT=4.
  -> Grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
  -> memWrEnable and memRdEnable never high together.
- Read with Size=11 on port 0.
  -> memRdEnable stays 0; p0RValid pulses with rData=0x0000; state returns to IDLE.
- Assert reset in the RESP cycle of a port-1 read.
  -> No p1RValid; all outputs 0 next cycle; busy=0.
  -> Next request is granted normally.
- Port-0 req raised during CMD of a port-1 write.
  -> Ignored until IDLE; p0Gnt appears in the cycle after the IDLE edge; port-1 write completed first.
